// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the seven-segment word presenter
package seven_seg_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 16;

    // 0.5 s dwell and 0.1 s blank gap at a 25 MHz clock
    localparam int DEFAULT_DWELL_CYCLES = 12_500_000;
    localparam int DEFAULT_GAP_CYCLES   = 2_500_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_HI = 2'd1,
        GAP     = 2'd2,
        SHOW_LO = 2'd3
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// rtl/seg_dwell_timer.sv - dwell counter with clear/enable and a terminal-count done flag
module seg_dwell_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term_cnt,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign done = enable && (count_q == term_cnt);

    // Saturates at the terminal count so a missed clear can never wrap.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !done) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seven_seg_word_presenter.sv
// rtl/seven_seg_word_presenter.sv - shows a 16-bit word as high then low byte on two digits
// Optional blank gap between the bytes is enabled by defining SEVSEG_GAP_EN.
module seven_seg_word_presenter
    import seven_seg_pkg::*;
#(
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                word_valid,
    input  logic [WORD_W-1:0]   word_data,
    output logic                word_ready,
    output logic [NIBBLE_W-1:0] digit_hi,
    output logic [NIBBLE_W-1:0] digit_lo,
    output logic                digit_blank,
    output logic                byte_sel,
    output logic                busy
);

`ifdef SEVSEG_GAP_EN
    localparam int CNT_W = max_int($clog2(DWELL_CYCLES + 1), $clog2(GAP_CYCLES + 1));
`else
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
`endif

    localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM   = CNT_W'(GAP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [NIBBLE_W-1:0] digit_hi_q, digit_hi_d;
    logic [NIBBLE_W-1:0] digit_lo_q, digit_lo_d;
    logic                blank_q, blank_d;
    logic                byte_sel_q, byte_sel_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;

    logic                tmr_clear;
    logic                tmr_done;
    logic [CNT_W-1:0]    tmr_term;

    // The GAP terminal is only ever selected when the GAP state is reachable.
    assign tmr_term = (state_q == GAP) ? GAP_TERM : DWELL_TERM;

    seg_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear),
        .enable   (busy_q),
        .term_cnt (tmr_term),
        .done     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        digit_hi_d = digit_hi_q;
        digit_lo_d = digit_lo_q;
        blank_d    = blank_q;
        byte_sel_d = byte_sel_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        tmr_clear  = 1'b0;

        case (state_q)
            IDLE: begin
                if (word_valid && ready_q) begin
                    state_d    = SHOW_HI;
                    word_d     = word_data;
                    digit_hi_d = word_data[15:12];
                    digit_lo_d = word_data[11:8];
                    blank_d    = 1'b0;
                    byte_sel_d = 1'b1;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                    tmr_clear  = 1'b1;
                end
            end
            SHOW_HI: begin
                if (tmr_done) begin
                    tmr_clear  = 1'b1;
                    byte_sel_d = 1'b0;
`ifdef SEVSEG_GAP_EN
                    state_d    = GAP;
                    blank_d    = 1'b1;
`else
                    state_d    = SHOW_LO;
                    digit_hi_d = word_q[7:4];
                    digit_lo_d = word_q[3:0];
`endif
                end
            end
`ifdef SEVSEG_GAP_EN
            GAP: begin
                if (tmr_done) begin
                    state_d    = SHOW_LO;
                    digit_hi_d = word_q[7:4];
                    digit_lo_d = word_q[3:0];
                    blank_d    = 1'b0;
                    tmr_clear  = 1'b1;
                end
            end
`endif
            SHOW_LO: begin
                if (tmr_done) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                    tmr_clear = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                blank_d    = 1'b1;
                byte_sel_d = 1'b0;
                busy_d     = 1'b0;
                ready_d    = 1'b1;
                tmr_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            digit_hi_q <= '0;
            digit_lo_q <= '0;
            blank_q    <= 1'b1;
            byte_sel_q <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            digit_hi_q <= digit_hi_d;
            digit_lo_q <= digit_lo_d;
            blank_q    <= blank_d;
            byte_sel_q <= byte_sel_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign word_ready  = ready_q;
    assign digit_hi    = digit_hi_q;
    assign digit_lo    = digit_lo_q;
    assign digit_blank = blank_q;
    assign byte_sel    = byte_sel_q;
    assign busy        = busy_q;

endmodule

// File: doc/seven_seg_word_presenter.md
Name: seven_seg_word_presenter

Overview:
- Upstream feeder for the Go Board's two seven-segment digit decoders.
- Accepts a 16-bit word from the CPU side over a valid/ready handshake.
- Presents the high byte, then the low byte, on two 4-bit nibble outputs, each for a programmable dwell time, then holds the low byte.
- Outputs are registered and connect directly to the two per-digit hex decoders.

Parameters:
- DWELL_CYCLES, 12500000, clock cycles each byte is shown (0.5 s at 25 MHz); must be >= 1.
- GAP_CYCLES, 2500000, blank cycles between high and low byte; used only when SEVSEG_GAP_EN is defined; must be >= 1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- word_valid  in  1  upstream has a word on word_data.
- word_data  in  16  word to display.
- word_ready  out  1  block can accept a word this cycle.
- digit_hi  out  4  nibble for left digit decoder.
- digit_lo  out  4  nibble for right digit decoder.
- digit_blank  out  1  1 = segments must be forced off downstream.
- byte_sel  out  1  1 while high byte is shown (drives an indicator LED).
- busy  out  1  1 while a presentation sequence is in progress.

Behaviour:
- Reset values: state IDLE, digit_hi=0, digit_lo=0, digit_blank=1, byte_sel=0, busy=0, word_ready=1, dwell count=0.
- word_ready=1 only in IDLE; it is a registered output, not a function of word_valid.
- Transfer occurs on a posedge where word_valid && word_ready.
- word_data must stay stable while word_valid=1 and word_ready=0.
  - word_valid may be held across a busy period; the transfer happens the first cycle back in IDLE.
- States and transitions:
  - IDLE: holds last displayed nibbles and blank state. On transfer, latch word_data into an internal register and go to SHOW_HI.
  - SHOW_HI: digit_hi=word[15:12], digit_lo=word[11:8], blank=0, byte_sel=1, busy=1, ready=0. After exactly DWELL_CYCLES cycles go to SHOW_LO (or GAP if the macro is defined).
  - SHOW_LO: digit_hi=word[7:4], digit_lo=word[3:0], blank=0, byte_sel=0, busy=1, ready=0. After exactly DWELL_CYCLES cycles go to IDLE.
  - IDLE after a sequence: nibbles stay at the low byte, blank=0, busy=0, ready=1.
- Latency: outputs reflect the new high byte on the cycle after the transfer edge.
- Total busy duration: 2*DWELL_CYCLES cycles, plus GAP_CYCLES when SEVSEG_GAP_EN is defined.
- Dwell counter:
  - Width $clog2(DWELL_CYCLES+1), or the larger of that and the GAP_CYCLES equivalent when the gap is enabled.
  - Clears on every state entry and counts 0..N-1; the state changes on the edge where the count equals N-1.
  - Never wraps in normal use.
- DWELL_CYCLES=1: each byte is shown for exactly one cycle.
- Back-to-back: with word_valid held high, the next transfer happens on the first IDLE cycle, so IDLE lasts 1 cycle between sequences.
- Reset mid-sequence: all outputs return to reset values immediately; the latched word is discarded and the sequence is not resumed.
- word_data changes while busy: ignored.

Optional Feature:
- Macro SEVSEG_GAP_EN.
- Defined: an extra GAP state sits between SHOW_HI and SHOW_LO.
  - GAP holds the previous nibbles, digit_blank=1, byte_sel=0, busy=1, ready=0, for exactly GAP_CYCLES cycles.
  - A repeated byte value is therefore visibly re-presented.
- Not defined: no GAP state exists, GAP_CYCLES is unused, and SHOW_HI goes directly to SHOW_LO.

Decomposition:
- Package seven_seg_pkg holds:
  - state enum (IDLE, SHOW_HI, GAP, SHOW_LO; GAP encoded unconditionally);
  - NIBBLE_W=4, WORD_W=16 constants;
  - default dwell/gap localparams for a 25 MHz clock.
- One natural sub-module, seg_dwell_timer:
  - parameterised terminal count, with clear and enable inputs and a done pulse;
  - shared with future display stages.

Test Plan (DWELL_CYCLES=4, GAP_CYCLES=2):
- Release reset, then pulse word_valid=1 with word_data=16'hA5C3 for one cycle -> next cycle digit_hi=A, digit_lo=5, byte_sel=1, busy=1, ready=0 for 4 cycles; then digit_hi=C, digit_lo=3, byte_sel=0 for 4 cycles; then IDLE with digits C/3, blank=0, ready=1.
- Hold word_valid=1 with 16'h1234, then 16'h5678 presented immediately after the first transfer -> 1234 presented in full; 5678 accepted on the single IDLE cycle; SHOW_HI for 5678 begins 1 cycle after the first sequence ends.
- Check state right after reset, before any word -> digit_blank=1, digits=0, ready=1; word_valid=0 for 20 cycles produces no state change.
- Assert rst_n=0 in the 2nd SHOW_LO cycle of 16'hBEEF -> outputs are reset values in the same cycle; after release, no resumption, ready=1.
- Change word_data to 16'hFFFF mid-sequence with word_valid=0 -> displayed nibbles unaffected.
- SEVSEG_GAP_EN defined, word 16'h7777 -> 4 cycles of 7/7, 2 cycles with digit_blank=1, 4 cycles of 7/7; busy is high for exactly 10 cycles.
